// File: rtl/chu_oled_ctrl.sv
// ---------------------------------------------------------------------------
// chu_oled_ctrl -- MMIO-slot controller for a PmodOLED-style SPI display.
//
// Sequences the display power rails (PMODEN -> RES pulse -> VCCEN -> ready,
// and VCCEN off -> discharge -> PMODEN off) and shifts single command/data
// bytes out over a mode-3, MSB-first SPI link.
//
// Ports
//   clk, reset_n          system clock, synchronous active-low reset
//   cs, read, write       MMIO slot strobes
//   addr[4:0]             0: status (RO), 1: control (WO), 2: data (WO)
//   wr_data[31:0]         control: bit0 power_on, bit1 power_off
//                         data:    bit8 D/C, bits7:0 byte
//   rd_data[31:0]         status: bit0 ready, bit1 xfer_busy, bit2 seq_busy
//   oled_sclk/mosi/cs_n   SPI link (sclk idles high)
//   oled_dc               data/command select, held between transfers
//   oled_res_n            display reset
//   oled_vccen            panel high-voltage enable
//   oled_pmoden           logic supply enable
// ---------------------------------------------------------------------------
module chu_oled_ctrl #(
    parameter int T_PWR    = 2_000_000,
    parameter int T_RES    = 300,
    parameter int T_VCC    = 10_000_000,
    parameter int SCLK_DIV = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        oled_sclk,
    output logic        oled_mosi,
    output logic        oled_cs_n,
    output logic        oled_dc,
    output logic        oled_res_n,
    output logic        oled_vccen,
    output logic        oled_pmoden
);

    localparam int T_MAX_PR = (T_PWR > T_RES) ? T_PWR : T_RES;
    localparam int T_MAX    = (T_MAX_PR > T_VCC) ? T_MAX_PR : T_VCC;
    localparam int CNT_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(T_RES - 1);
    localparam logic [CNT_W-1:0] VCC_LAST = CNT_W'(T_VCC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    // Half-bit phases 0..15 carry the 8 bits (even = sclk low, odd = sclk
    // high); phase 16 is the trailing cs_n hold after the last rising edge.
    localparam logic [4:0] HALF_LAST_BIT = 5'd15;
    localparam logic [4:0] HALF_TAIL     = 5'd16;

    typedef enum logic [2:0] {
        S_OFF,
        S_PWR_WAIT,
        S_RES_LO,
        S_RES_WAIT,
        S_VCC_WAIT,
        S_READY,
        S_XFER,
        S_DOWN_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       half_q, half_d;
    logic [7:0]       shift_q, shift_d;
    logic             pending_off_q, pending_off_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             dc_q, dc_d;
    logic             res_n_q, res_n_d;
    logic             vccen_q, vccen_d;
    logic             pmoden_q, pmoden_d;
    logic             go_down;

    // Bus decode. power_off has priority when both control bits are set.
    logic wr_en, ctrl_wr, data_wr, power_on, power_off;
    assign wr_en     = cs & write;
    assign ctrl_wr   = wr_en && (addr == 5'd1);
    assign data_wr   = wr_en && (addr == 5'd2);
    assign power_off = ctrl_wr & wr_data[1];
    assign power_on  = ctrl_wr & wr_data[0] & ~wr_data[1];

    // Status is the only readable register, so it is returned unconditionally.
    logic ready, xfer_busy, seq_busy;
    assign ready     = (state_q == S_READY);
    assign xfer_busy = (state_q == S_XFER);
    assign seq_busy  = (state_q == S_PWR_WAIT) || (state_q == S_RES_LO) ||
                       (state_q == S_RES_WAIT) || (state_q == S_VCC_WAIT) ||
                       (state_q == S_DOWN_WAIT);
    assign rd_data   = {29'd0, seq_busy, xfer_busy, ready};

    logic unused_inputs;
    assign unused_inputs = &{1'b0, read, wr_data[31:9]};

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        cnt_d         = '0;
        div_d         = '0;
        half_d        = '0;
        shift_d       = shift_q;
        pending_off_d = pending_off_q;
        sclk_d        = sclk_q;
        mosi_d        = mosi_q;
        cs_n_d        = cs_n_q;
        dc_d          = dc_q;
        res_n_d       = res_n_q;
        vccen_d       = vccen_q;
        pmoden_d      = pmoden_q;
        go_down       = 1'b0;

        // Counters default to zero, so any branch that changes state leaves
        // them cleared for the next state.
        unique case (state_q)
            S_OFF: begin
                if (power_on) begin
                    pmoden_d = 1'b1;
                    state_d  = S_PWR_WAIT;
                end
            end
            S_PWR_WAIT: begin
                if (power_off)             go_down = 1'b1;
                else if (cnt_q == PWR_LAST) begin
                    res_n_d = 1'b0;
                    state_d = S_RES_LO;
                end else                   cnt_d = cnt_q + 1'b1;
            end
            S_RES_LO: begin
                if (power_off)             go_down = 1'b1;
                else if (cnt_q == RES_LAST) begin
                    res_n_d = 1'b1;
                    state_d = S_RES_WAIT;
                end else                   cnt_d = cnt_q + 1'b1;
            end
            S_RES_WAIT: begin
                if (power_off)             go_down = 1'b1;
                else if (cnt_q == RES_LAST) begin
                    vccen_d = 1'b1;
                    state_d = S_VCC_WAIT;
                end else                   cnt_d = cnt_q + 1'b1;
            end
            S_VCC_WAIT: begin
                if (power_off)             go_down = 1'b1;
                else if (cnt_q == VCC_LAST) state_d = S_READY;
                else                       cnt_d = cnt_q + 1'b1;
            end
            S_READY: begin
                if (power_off) begin
                    go_down = 1'b1;
                end else if (data_wr) begin
                    // First falling sclk edge coincides with cs_n assertion,
                    // so bit 7 is presented right away.
                    dc_d    = wr_data[8];
                    shift_d = wr_data[7:0];
                    mosi_d  = wr_data[7];
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (power_off) pending_off_d = 1'b1;
                if (div_q != DIV_LAST) begin
                    div_d  = div_q + 1'b1;
                    half_d = half_q;
                end else if (half_q == HALF_TAIL) begin
                    cs_n_d = 1'b1;
                    if (pending_off_q || power_off) go_down = 1'b1;
                    else                            state_d = S_READY;
                end else begin
                    half_d = half_q + 1'b1;
                    if (!half_q[0]) begin
                        sclk_d = 1'b1;
                    end else if (half_q != HALF_LAST_BIT) begin
                        // Falling edge: the only place mosi is allowed to move.
                        sclk_d  = 1'b0;
                        mosi_d  = shift_q[6];
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            S_DOWN_WAIT: begin
                if (cnt_q == VCC_LAST) begin
                    pmoden_d = 1'b0;
                    state_d  = S_OFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase

        // Shared power-down entry: panel rail off first, logic rail later.
        if (go_down) begin
            state_d       = S_DOWN_WAIT;
            vccen_d       = 1'b0;
            res_n_d       = 1'b1;
            sclk_d        = 1'b1;
            cs_n_d        = 1'b1;
            pending_off_d = 1'b0;
            cnt_d         = '0;
            div_d         = '0;
            half_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its peers.
        if (!reset_n) begin
            state_q       <= S_OFF;
            cnt_q         <= '0;
            div_q         <= '0;
            half_q        <= '0;
            shift_q       <= '0;
            pending_off_q <= 1'b0;
            sclk_q        <= 1'b1;
            mosi_q        <= 1'b0;
            cs_n_q        <= 1'b1;
            dc_q          <= 1'b0;
            res_n_q       <= 1'b1;
            vccen_q       <= 1'b0;
            pmoden_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            half_q        <= half_d;
            shift_q       <= shift_d;
            pending_off_q <= pending_off_d;
            sclk_q        <= sclk_d;
            mosi_q        <= mosi_d;
            cs_n_q        <= cs_n_d;
            dc_q          <= dc_d;
            res_n_q       <= res_n_d;
            vccen_q       <= vccen_d;
            pmoden_q      <= pmoden_d;
        end
    end

    assign oled_sclk   = sclk_q;
    assign oled_mosi   = mosi_q;
    assign oled_cs_n   = cs_n_q;
    assign oled_dc     = dc_q;
    assign oled_res_n  = res_n_q;
    assign oled_vccen  = vccen_q;
    assign oled_pmoden = pmoden_q;

endmodule
